cpu_clk_sched: RTL and testbench

Run/halt/step scheduler for the RV32I core clock. It replaces a fixed-ratio clock toggle with a single-cycle clock-enable pulse, `cpu_ce`, on the board clock domain. The divide ratio is programmable at runtime. Debug control supports free run, halt, single step, N-tick burst and breakpoint stop. The block sits between the board/debug inputs and the processor's pipeline-register enables.

---
 rtl/cpu_clk_sched_pkg.sv | 18 +
 rtl/ce_prescaler.sv | 52 +++++
 rtl/cpu_clk_sched.sv | 131 +++++++++++++
 tb/tb_cpu_clk_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_clk_sched_pkg
//  Brief    : State encoding and width defaults for the CPU clock scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_clk_sched_pkg;

    localparam int DIV_W_DEF   = 32;
    localparam int BURST_W_DEF = 16;

    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_BURST = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ce_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : ce_prescaler
//  Brief    : Loadable divisor register and prescaler counter with terminal.
//  Revision : 1.0 - initial release
// ============================================================================
module ce_prescaler
    import cpu_clk_sched_pkg::*;
#(
    parameter int          DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             div_ld,
    input  logic [DIV_W-1:0] div_val,
    output logic             terminal
);

    localparam logic [DIV_W-1:0] C_ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] C_DEF_DIV = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_div_m1;

    // r_div is never 0, so div-1 cannot underflow; >= keeps a shrunk divisor safe
    assign w_div_m1 = r_div - C_ONE;
    assign terminal = enable && (r_cnt >= w_div_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= C_DEF_DIV;
        end else if (div_ld) begin
            r_div <= (div_val == '0) ? C_ONE : div_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || terminal) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_clk_sched.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_clk_sched
//  Brief    : Run/halt/step/burst scheduler producing a one-cycle CPU clock enable.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_clk_sched
    import cpu_clk_sched_pkg::*;
#(
    parameter int          DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = 1,
    parameter int          BURST_W     = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_ld,
    input  logic [DIV_W-1:0]   div_val,
    input  logic               run_req,
    input  logic               halt_req,
    input  logic               step_req,
    input  logic               burst_req,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               brk_hit,
    output logic               cpu_ce,
    output logic [1:0]         state,
    output logic               busy,
    output logic               halted_pulse,
    output logic [31:0]        tick_count
);

    localparam logic [BURST_W-1:0] C_REM_ONE = BURST_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [BURST_W-1:0] r_rem;
    logic [BURST_W-1:0] w_rem_nxt;
    logic               r_ce;
    logic               w_ce_nxt;
    logic               r_hp;
    logic               w_hp_nxt;
    logic [31:0]        r_tick_cnt;
    logic               w_active;
    logic               w_stop;
    logic               w_terminal;

    assign w_active = (r_state != ST_HALT);
    assign w_stop   = w_active && (halt_req || brk_hit);

    // Counter sits at 0 in HALT and is wiped on any stop
    ce_prescaler #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clear    (!w_active || w_stop),
        .enable   (w_active),
        .div_ld   (div_ld),
        .div_val  (div_val),
        .terminal (w_terminal)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_ce_nxt    = 1'b0;
        w_hp_nxt    = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (run_req) begin
                    w_state_nxt = ST_RUN;
                end else if (burst_req && (burst_len != '0)) begin
                    w_state_nxt = ST_BURST;
                    w_rem_nxt   = burst_len;
                end else if (step_req) begin
                    w_state_nxt = ST_STEP;
                end
            end
            default: begin
                if (w_stop) begin
                    w_state_nxt = ST_HALT;
                    w_rem_nxt   = '0;
                    w_hp_nxt    = 1'b1;
                end else if (w_terminal) begin
                    w_ce_nxt = 1'b1;
                    case (r_state)
                        ST_STEP: begin
                            w_state_nxt = ST_HALT;
                            w_hp_nxt    = 1'b1;
                        end
                        ST_BURST: begin
                            w_rem_nxt = r_rem - C_REM_ONE;
                            if (r_rem == C_REM_ONE) begin
                                w_state_nxt = ST_HALT;
                                w_hp_nxt    = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_HALT;
            r_rem      <= '0;
            r_ce       <= 1'b0;
            r_hp       <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_ce    <= w_ce_nxt;
            r_hp    <= w_hp_nxt;
            if (w_ce_nxt) begin
                r_tick_cnt <= r_tick_cnt + 32'd1;
            end
        end
    end

    assign cpu_ce       = r_ce;
    assign state        = r_state;
    assign busy         = w_active;
    assign halted_pulse = r_hp;
    assign tick_count   = r_tick_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_clk_sched
//  Brief    : Directed vector table plus corner sequences for cpu_clk_sched.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_clk_sched;
    import cpu_clk_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_ld = 1'b0;
    logic [31:0] div_val = '0;
    logic        run_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic        burst_req = 1'b0;
    logic [15:0] burst_len = '0;
    logic        brk_hit = 1'b0;
    logic        cpu_ce;
    logic [1:0]  state;
    logic        busy;
    logic        halted_pulse;
    logic [31:0] tick_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_tc   = 0;

    always #5 clk = ~clk;

    cpu_clk_sched #(
        .DIV_W       (32),
        .DEFAULT_DIV (1),
        .BURST_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .div_ld       (div_ld),
        .div_val      (div_val),
        .run_req      (run_req),
        .halt_req     (halt_req),
        .step_req     (step_req),
        .burst_req    (burst_req),
        .burst_len    (burst_len),
        .brk_hit      (brk_hit),
        .cpu_ce       (cpu_ce),
        .state        (state),
        .busy         (busy),
        .halted_pulse (halted_pulse),
        .tick_count   (tick_count)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] div;
        logic [15:0] blen;
        int          win;
        int          exp_st0;
        int          exp_ticks;
        int          exp_first;
        int          exp_hp;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic load_div(input logic [31:0] d);
        div_ld  = 1'b1;
        div_val = d;
        tick();
        div_ld  = 1'b0;
    endtask

    task automatic halt_now();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
    endtask

    initial begin
        int ticks, first, hps;

        vecs[0] = '{ST_RUN,   32'd4, 16'd0, 13, 1, 3,  4, 0};
        vecs[1] = '{ST_STEP,  32'd3, 16'd0, 10, 2, 1,  3, 1};
        vecs[2] = '{ST_STEP,  32'd3, 16'd0, 10, 2, 1,  3, 1};
        vecs[3] = '{ST_BURST, 32'd1, 16'd5, 10, 3, 5,  1, 1};
        vecs[4] = '{ST_BURST, 32'd1, 16'd0,  6, 0, 0, -1, 0};
        vecs[5] = '{ST_RUN,   32'd1, 16'd0,  6, 1, 5,  1, 0};
        vecs[6] = '{ST_RUN,   32'd0, 16'd0,  6, 1, 5,  1, 0};
        vecs[7] = '{ST_BURST, 32'd2, 16'd3, 10, 3, 3,  2, 1};
        vecs[8] = '{ST_STEP,  32'd1, 16'd0,  4, 2, 1,  1, 1};

        #12;
        chk("reset_state", int'(state), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ce", int'(cpu_ce), 0);
        chk("reset_hp", int'(halted_pulse), 0);
        chk("reset_tick", int'(tick_count), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            load_div(vecs[v].div);
            case (vecs[v].op)
                ST_RUN:   run_req = 1'b1;
                ST_STEP:  step_req = 1'b1;
                default: begin
                    burst_req = 1'b1;
                    burst_len = vecs[v].blen;
                end
            endcase
            ticks = 0;
            first = -1;
            hps   = 0;
            for (int k = 0; k < vecs[v].win; k++) begin
                tick();
                if (k == 0) begin
                    run_req   = 1'b0;
                    step_req  = 1'b0;
                    burst_req = 1'b0;
                    chk($sformatf("v%0d_state0", v), int'(state), vecs[v].exp_st0);
                    chk($sformatf("v%0d_busy0", v), int'(busy), int'(vecs[v].exp_st0 != 0));
                end
                if (cpu_ce) begin
                    ticks++;
                    if (first < 0) first = k;
                end
                if (halted_pulse) begin
                    hps++;
                    chk($sformatf("v%0d_hp_state", v), int'(state), 0);
                end
            end
            chk($sformatf("v%0d_ticks", v), ticks, vecs[v].exp_ticks);
            chk($sformatf("v%0d_first", v), first, vecs[v].exp_first);
            chk($sformatf("v%0d_hp", v), hps, vecs[v].exp_hp);
            exp_tc += vecs[v].exp_ticks;
            if (vecs[v].op == ST_RUN) begin
                halt_now();
                chk($sformatf("v%0d_halt_state", v), int'(state), 0);
                chk($sformatf("v%0d_halt_ce", v), int'(cpu_ce), 0);
                chk($sformatf("v%0d_halt_hp", v), int'(halted_pulse), 1);
                tick();
                chk($sformatf("v%0d_halt_hp_gone", v), int'(halted_pulse), 0);
                chk($sformatf("v%0d_halt_ce2", v), int'(cpu_ce), 0);
            end else begin
                chk($sformatf("v%0d_end_state", v), int'(state), 0);
            end
            chk($sformatf("v%0d_tick_count", v), int'(tick_count), exp_tc);
        end

        // coincident stop: brk_hit arrives on the terminal edge
        load_div(32'd2);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        tick();
        tick();
        chk("brk_first_tick", int'(cpu_ce), 1);
        exp_tc++;
        tick();
        brk_hit = 1'b1;
        tick();
        chk("brk_no_tick", int'(cpu_ce), 0);
        chk("brk_state", int'(state), 0);
        chk("brk_hp", int'(halted_pulse), 1);
        load_div(32'd1);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("brk_rerun_state", int'(state), 1);
        tick();
        chk("brk_block_state", int'(state), 0);
        chk("brk_block_hp", int'(halted_pulse), 1);
        chk("brk_block_ce", int'(cpu_ce), 0);
        tick();
        brk_hit = 1'b0;
        chk("brk_tick_count", int'(tick_count), exp_tc);

        // divisor shrink mid-count
        load_div(32'd10);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        div_ld  = 1'b1;
        div_val = 32'd2;
        tick();
        div_ld  = 1'b0;
        chk("shrink_e7", int'(cpu_ce), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("shrink_e%0d", k + 8), int'(cpu_ce), int'(k % 2 == 0));
        end
        exp_tc += 3;
        halt_now();
        chk("shrink_halt", int'(state), 0);
        chk("shrink_tick_count", int'(tick_count), exp_tc);

        // asynchronous reset in the middle of a long burst
        load_div(32'd1);
        burst_req = 1'b1;
        burst_len = 16'd100;
        tick();
        burst_req = 1'b0;
        ticks = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cpu_ce) ticks++;
        end
        chk("rst_burst_ticks", ticks, 20);
        exp_tc += 20;
        chk("rst_burst_count", int'(tick_count), exp_tc);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_state", int'(state), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_ce", int'(cpu_ce), 0);
        chk("rst_async_hp", int'(halted_pulse), 0);
        chk("rst_async_tick", int'(tick_count), 0);
        exp_tc = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        exp_tc++;
        chk("rst_step_count", int'(tick_count), exp_tc);
        chk("rst_step_state", int'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
